// File: rtl/depp_wb_bridge.sv
// depp_wb_bridge: DEPP 8-bit host port driving a 32-bit pipelined Wishbone master.
// Also carries a combinational Pi header <-> DEPP pin pass-through.
module depp_wb_bridge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_astb_n,
   input  logic        i_dstb_n,
   input  logic        i_write_n,
   input  logic [7:0]  i_depp,
   output logic [7:0]  o_depp,
   output logic        o_wait,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic        i_wb_err,
   input  logic [31:0] i_wb_data,
   input  logic        i_int,
   input  logic [7:0]  i_rpi2B,
   input  logic [7:0]  fr_depp,
   output logic [7:0]  o_rpi2B,
   output logic [7:0]  to_depp
);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      RELEASE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [SYNC_STAGES-1:0] astb_q;
   logic [SYNC_STAGES-1:0] dstb_q;
   logic [SYNC_STAGES-1:0] wr_q;
   logic [SYNC_STAGES-1:0] int_q;

   logic        astb_s;
   logic        dstb_s;
   logic        wr_s;
   logic        int_s;
   logic        int_d;
   logic [3:0]  idx;
   logic [31:0] rdata;
   logic        err;
   logic        int_pend;
   logic        busy;
   logic        blocked;
   logic        addr_wr;
   logic        addr_rd;
   logic        data_wr;
   logic        data_rd;
   logic        launch_wr;
   logic        launch_rd;
   logic        int_clr;
   logic        int_rise;
   logic [7:0]  status;
   logic [31:0] rd_word;
   logic [7:0]  rd_byte;

   assign o_rpi2B = fr_depp;
   assign to_depp = i_rpi2B;

   assign astb_s = astb_q[SYNC_STAGES-1];
   assign dstb_s = dstb_q[SYNC_STAGES-1];
   assign wr_s   = wr_q[SYNC_STAGES-1];
   assign int_s  = int_q[SYNC_STAGES-1];

   assign busy     = o_wb_cyc;
   // Writes that touch the bus registers or start a cycle wait for the bus
   assign blocked  = busy && (!idx[3] || (idx == 4'hf && i_depp[0]));
   assign launch_wr = data_wr && idx == 4'h7;
   assign launch_rd = data_wr && idx == 4'hf && i_depp[0];
   assign int_clr   = data_wr && idx == 4'hf && i_depp[3];
   assign int_rise  = int_s && !int_d;
   assign status    = {4'h0, int_pend, int_s, err, busy};

   // Synchronize host strobes, direction and interrupt into i_clk
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         astb_q <= '1;
         dstb_q <= '1;
         wr_q   <= '1;
         int_q  <= '0;
         int_d  <= 1'b0;
      end else begin
         astb_q <= {astb_q[SYNC_STAGES-2:0], i_astb_n};
         dstb_q <= {dstb_q[SYNC_STAGES-2:0], i_dstb_n};
         wr_q   <= {wr_q[SYNC_STAGES-2:0], i_write_n};
         int_q  <= {int_q[SYNC_STAGES-2:0], i_int};
         int_d  <= int_s;
      end
   end

   // Handshake state register; wait is high exactly while in HOLD
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         o_wait <= 1'b0;
      end else begin
         state  <= state_nx;
         o_wait <= (state_nx == HOLD);
      end
   end

   // Handshake next state and transfer strobes; address strobe has priority
   always_comb begin
      state_nx = state;
      addr_wr  = 1'b0;
      addr_rd  = 1'b0;
      data_wr  = 1'b0;
      data_rd  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!astb_s) begin
               addr_wr  = !wr_s;
               addr_rd  = wr_s;
               state_nx = HOLD;
            end else if (!dstb_s) begin
               if (wr_s) begin
                  data_rd  = 1'b1;
                  state_nx = HOLD;
               end else if (!blocked) begin
                  data_wr  = 1'b1;
                  state_nx = HOLD;
               end
            end
         end
         HOLD: begin
            if (astb_s && dstb_s) state_nx = RELEASE;
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Select the register byte addressed by idx for host reads
   always_comb begin
      rd_word = 32'h0;
      rd_byte = 8'h00;
      unique case (idx[3:2])
         2'd0: rd_word = o_wb_addr;
         2'd1: rd_word = o_wb_data;
         2'd2: rd_word = rdata;
         2'd3: rd_word = 32'h0;
      endcase
      unique case (idx[1:0])
         2'd0: rd_byte = rd_word[31:24];
         2'd1: rd_byte = rd_word[23:16];
         2'd2: rd_byte = rd_word[15:8];
         2'd3: rd_byte = rd_word[7:0];
      endcase
      if (idx == 4'hf) rd_byte = status;
   end

   // Register index loaded by host address writes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) idx <= 4'h0;
      else if (addr_wr) idx <= i_depp[3:0];
   end

   // Byte returned to the host on address or data reads
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_depp <= 8'h00;
      else if (addr_rd) o_depp <= {4'h0, idx};
      else if (data_rd) o_depp <= rd_byte;
   end

   // Host writes into the bus address and write-data bytes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_addr <= 32'h0;
         o_wb_data <= 32'h0;
      end else if (data_wr && !idx[3]) begin
         unique case (idx[2:0])
            3'd0: o_wb_addr[31:24] <= i_depp;
            3'd1: o_wb_addr[23:16] <= i_depp;
            3'd2: o_wb_addr[15:8]  <= i_depp;
            3'd3: o_wb_addr[7:0]   <= i_depp;
            3'd4: o_wb_data[31:24] <= i_depp;
            3'd5: o_wb_data[23:16] <= i_depp;
            3'd6: o_wb_data[15:8]  <= i_depp;
            3'd7: o_wb_data[7:0]   <= i_depp;
         endcase
      end
   end

   // Single pipelined transaction: stb until accepted, cyc until ack/err
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_cyc <= 1'b0;
         o_wb_stb <= 1'b0;
         o_wb_we  <= 1'b0;
         err      <= 1'b0;
         rdata    <= 32'h0;
      end else if (launch_wr || launch_rd) begin
         o_wb_cyc <= 1'b1;
         o_wb_stb <= 1'b1;
         o_wb_we  <= launch_wr;
         err      <= 1'b0;
      end else if (o_wb_cyc) begin
         if (!i_wb_stall) o_wb_stb <= 1'b0;
         if (i_wb_ack || i_wb_err) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
         end
         if (i_wb_err) err <= 1'b1;
         else if (i_wb_ack && !o_wb_we) rdata <= i_wb_data;
      end
   end

   // Sticky interrupt pending; a new edge beats a same-cycle clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) int_pend <= 1'b0;
      else if (int_rise) int_pend <= 1'b1;
      else if (int_clr) int_pend <= 1'b0;
   end

endmodule

// File: tb/tb_depp_wb_bridge.sv
// tb_depp_wb_bridge: directed bench for the DEPP to Wishbone bridge.
// Host handshakes and a small Wishbone slave are driven from initial blocks.
module tb_depp_wb_bridge;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_astb_n = 1'b1;
   logic        i_dstb_n = 1'b1;
   logic        i_write_n = 1'b1;
   logic [7:0]  i_depp = 8'h00;
   logic [7:0]  o_depp;
   logic        o_wait;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [31:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic        i_wb_ack;
   logic        i_wb_stall;
   logic        i_wb_err;
   logic [31:0] i_wb_data;
   logic        i_int = 1'b0;
   logic [7:0]  i_rpi2B = 8'h00;
   logic [7:0]  fr_depp = 8'h00;
   logic [7:0]  o_rpi2B;
   logic [7:0]  to_depp;

   int total = 0;
   int bad = 0;

   int          stall_n = 0;
   int          ack_dly = 0;
   bit          err_mode = 1'b0;
   logic [31:0] rd_val = 32'h0;
   int          cyc_cnt = 0;
   int          done_cnt = 0;
   int          acc_cnt = 0;
   logic        s_we = 1'b0;
   logic [31:0] s_addr = 32'h0;
   logic [31:0] s_data = 32'h0;

   depp_wb_bridge #(.SYNC_STAGES(2)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_astb_n   (i_astb_n),
      .i_dstb_n   (i_dstb_n),
      .i_write_n  (i_write_n),
      .i_depp     (i_depp),
      .o_depp     (o_depp),
      .o_wait     (o_wait),
      .o_wb_cyc   (o_wb_cyc),
      .o_wb_stb   (o_wb_stb),
      .o_wb_we    (o_wb_we),
      .o_wb_addr  (o_wb_addr),
      .o_wb_data  (o_wb_data),
      .i_wb_ack   (i_wb_ack),
      .i_wb_stall (i_wb_stall),
      .i_wb_err   (i_wb_err),
      .i_wb_data  (i_wb_data),
      .i_int      (i_int),
      .i_rpi2B    (i_rpi2B),
      .fr_depp    (fr_depp),
      .o_rpi2B    (o_rpi2B),
      .to_depp    (to_depp)
   );

   always #5 i_clk = ~i_clk;

   // Count strobes the slave accepts
   always @(posedge i_clk) begin
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) acc_cnt <= acc_cnt + 1;
   end

   // Wishbone slave: stall stall_n cycles, then ack/err ack_dly cycles later
   initial begin
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      i_wb_stall = 1'b0;
      i_wb_data = 32'h0;
      forever begin
         @(negedge i_clk);
         if (o_wb_cyc && o_wb_stb) begin
            cyc_cnt++;
            s_we = o_wb_we;
            s_addr = o_wb_addr;
            s_data = o_wb_data;
            i_wb_stall = (stall_n > 0);
            repeat (stall_n) @(negedge i_clk);
            i_wb_stall = 1'b0;
            @(negedge i_clk);
            repeat (ack_dly) @(negedge i_clk);
            i_wb_ack = !err_mode;
            i_wb_err = err_mode;
            i_wb_data = rd_val;
            done_cnt++;
            @(negedge i_clk);
            i_wb_ack = 1'b0;
            i_wb_err = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_hi();
      int n = 0;
      while (o_wait !== 1'b1 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      chk("wait_hi", {31'h0, o_wait}, 32'h1);
   endtask

   task automatic wait_lo();
      int n = 0;
      while (o_wait !== 1'b0 && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk("wait_lo", {31'h0, o_wait}, 32'h0);
   endtask

   task automatic xfer(input bit is_addr, input bit wr,
                       input logic [7:0] wd, output logic [7:0] rd);
      i_write_n = !wr;
      i_depp = wd;
      @(negedge i_clk);
      if (is_addr) i_astb_n = 1'b0;
      else i_dstb_n = 1'b0;
      wait_hi();
      rd = o_depp;
      i_astb_n = 1'b1;
      i_dstb_n = 1'b1;
      wait_lo();
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
      logic [7:0] x;
      xfer(1'b1, 1'b1, {4'h0, a}, x);
      xfer(1'b0, 1'b1, d, x);
   endtask

   task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
      logic [7:0] x;
      xfer(1'b1, 1'b1, {4'h0, a}, x);
      xfer(1'b0, 1'b0, 8'h00, d);
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while ((done_cnt != target || o_wb_cyc) && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      chk("bus_done", done_cnt, target);
      chk("bus_idle", {31'h0, o_wb_cyc}, 32'h0);
   endtask

   initial begin
      logic [7:0] b;
      int a0;
      int c0;
      int d0;

      i_rpi2B = 8'hA5;
      fr_depp = 8'h3C;
      #1;
      chk("rst_to_depp", {24'h0, to_depp}, 32'hA5);
      chk("rst_o_rpi", {24'h0, o_rpi2B}, 32'h3C);
      chk("rst_depp", {24'h0, o_depp}, 32'h0);
      chk("rst_wait", {31'h0, o_wait}, 32'h0);
      chk("rst_cyc", {29'h0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'h0);
      chk("rst_addr", o_wb_addr, 32'h0);
      chk("rst_data", o_wb_data, 32'h0);
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (3) @(negedge i_clk);

      xfer(1'b1, 1'b1, 8'h0B, b);
      xfer(1'b1, 1'b0, 8'h00, b);
      chk("idx_read", {24'h0, b}, 32'h0B);

      stall_n = 2;
      ack_dly = 0;
      a0 = acc_cnt;
      d0 = done_cnt;
      wr_reg(4'h0, 8'h00);
      wr_reg(4'h1, 8'h00);
      wr_reg(4'h2, 8'h10);
      wr_reg(4'h3, 8'h00);
      wr_reg(4'h4, 8'hDE);
      wr_reg(4'h5, 8'hAD);
      wr_reg(4'h6, 8'hBE);
      wr_reg(4'h7, 8'hEF);
      wait_done(d0 + 1);
      chk("wr_accepts", acc_cnt - a0, 32'd1);
      chk("wr_we", {31'h0, s_we}, 32'h1);
      chk("wr_addr", s_addr, 32'h00001000);
      chk("wr_data", s_data, 32'hDEADBEEF);
      chk("wr_addr_hold", o_wb_addr, 32'h00001000);
      rd_reg(4'hf, b);
      chk("wr_status", {24'h0, b}, 32'h00);

      stall_n = 0;
      rd_val = 32'h12345678;
      d0 = done_cnt;
      wr_reg(4'hf, 8'h01);
      wait_done(d0 + 1);
      chk("rd_we", {31'h0, s_we}, 32'h0);
      rd_reg(4'h8, b);
      chk("rd_b8", {24'h0, b}, 32'h12);
      rd_reg(4'h9, b);
      chk("rd_b9", {24'h0, b}, 32'h34);
      rd_reg(4'hA, b);
      chk("rd_b10", {24'h0, b}, 32'h56);
      rd_reg(4'hB, b);
      chk("rd_b11", {24'h0, b}, 32'h78);
      wr_reg(4'h9, 8'hFF);
      rd_reg(4'h9, b);
      chk("rd_ro", {24'h0, b}, 32'h34);
      rd_reg(4'hC, b);
      chk("rd_b12", {24'h0, b}, 32'h00);

      err_mode = 1'b1;
      rd_val = 32'hCAFEF00D;
      d0 = done_cnt;
      wr_reg(4'hf, 8'h01);
      wait_done(d0 + 1);
      rd_reg(4'hf, b);
      chk("err_status", {24'h0, b}, 32'h02);
      rd_reg(4'h8, b);
      chk("err_keep8", {24'h0, b}, 32'h12);
      rd_reg(4'hB, b);
      chk("err_keep11", {24'h0, b}, 32'h78);
      err_mode = 1'b0;
      rd_val = 32'h0BADC0DE;
      d0 = done_cnt;
      wr_reg(4'hf, 8'h01);
      wait_done(d0 + 1);
      rd_reg(4'hf, b);
      chk("err_clear", {24'h0, b}, 32'h00);
      rd_reg(4'h8, b);
      chk("err_new8", {24'h0, b}, 32'h0B);

      stall_n = 25;
      ack_dly = 2;
      rd_val = 32'h55AA55AA;
      c0 = cyc_cnt;
      d0 = done_cnt;
      wr_reg(4'h7, 8'hEF);
      xfer(1'b1, 1'b1, 8'h0F, b);
      i_write_n = 1'b0;
      i_depp = 8'h01;
      @(negedge i_clk);
      i_dstb_n = 1'b0;
      repeat (4) @(negedge i_clk);
      chk("busy_wait_low", {31'h0, o_wait}, 32'h0);
      chk("busy_cyc", {31'h0, o_wb_cyc}, 32'h1);
      chk("busy_first_open", done_cnt, d0);
      wait_hi();
      chk("busy_first_done", done_cnt, d0 + 1);
      i_dstb_n = 1'b1;
      wait_lo();
      wait_done(d0 + 2);
      chk("busy_two_cycles", cyc_cnt - c0, 32'd2);
      chk("busy_second_we", {31'h0, s_we}, 32'h0);
      rd_reg(4'h8, b);
      chk("busy_rd8", {24'h0, b}, 32'h55);

      i_int = 1'b1;
      repeat (4) @(negedge i_clk);
      rd_reg(4'hf, b);
      chk("int_high", {24'h0, b}, 32'h0C);
      i_int = 1'b0;
      repeat (4) @(negedge i_clk);
      rd_reg(4'hf, b);
      chk("int_pend", {24'h0, b}, 32'h08);
      wr_reg(4'hf, 8'h08);
      rd_reg(4'hf, b);
      chk("int_clr", {24'h0, b}, 32'h00);

      i_rpi2B = 8'h5A;
      fr_depp = 8'hC3;
      #1;
      chk("pt_to_depp", {24'h0, to_depp}, 32'h5A);
      chk("pt_o_rpi", {24'h0, o_rpi2B}, 32'hC3);

      stall_n = 30;
      ack_dly = 0;
      rd_reg(4'h4, b);
      chk("pre_rd4", {24'h0, b}, 32'hDE);
      xfer(1'b1, 1'b1, 8'h07, b);
      i_write_n = 1'b0;
      i_depp = 8'hEF;
      @(negedge i_clk);
      i_dstb_n = 1'b0;
      wait_hi();
      chk("pre_cyc", {30'h0, o_wb_cyc, o_wb_stb}, 32'h3);
      chk("pre_depp", {24'h0, o_depp}, 32'hDE);
      i_rpi2B = 8'hA5;
      fr_depp = 8'h3C;
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_cyc", {29'h0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'h0);
      chk("mid_rst_wait", {31'h0, o_wait}, 32'h0);
      chk("mid_rst_depp", {24'h0, o_depp}, 32'h0);
      chk("mid_rst_addr", o_wb_addr, 32'h0);
      chk("mid_rst_to_depp", {24'h0, to_depp}, 32'hA5);
      chk("mid_rst_o_rpi", {24'h0, o_rpi2B}, 32'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
